// File: rtl/fila_requisicoes_pkg.sv
// Shared definitions for the request buffer: dispatch FSM states and floor/entry widths.
package fila_requisicoes_pkg;

  localparam int LARGURA_ANDAR   = 4;
  localparam int LARGURA_ENTRADA = 2 * LARGURA_ANDAR;

  typedef enum logic [1:0] {
    ST_OCIOSO    = 2'd0,
    ST_CARREGA   = 2'd1,
    ST_PULSO     = 2'd2,
    ST_INTERVALO = 2'd3
  } estado_t;

  function automatic int maxInt(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/fifo_requisicoes.sv
// Circular FIFO of {origem,destino} pairs; pointers carry one extra wrap bit.
module fifo_requisicoes
  import fila_requisicoes_pkg::*;
#(
  parameter int PROFUNDIDADE = 4
) (
  input  logic                       clock,
  input  logic                       reset,
  input  logic                       push,
  input  logic                       pop,
  input  logic [LARGURA_ENTRADA-1:0] dadoEntrada,
  output logic [LARGURA_ENTRADA-1:0] dadoSaida,
  output logic                       vazia,
  output logic                       cheia,
  output logic [4:0]                 ocupacao
);

  localparam int AW = $clog2(PROFUNDIDADE);
  localparam logic [AW:0] UM = 1;

  logic [LARGURA_ENTRADA-1:0] mem [PROFUNDIDADE];
  logic [AW:0] wrPtr, rdPtr, diferenca;
  logic        doPush, doPop;

  assign vazia     = (wrPtr == rdPtr);
  assign cheia     = (wrPtr[AW] != rdPtr[AW]) && (wrPtr[AW-1:0] == rdPtr[AW-1:0]);
  assign doPop     = pop && !vazia;
  // A pop in the same cycle frees the slot, so a full FIFO can still accept.
  assign doPush    = push && (!cheia || doPop);
  assign diferenca = wrPtr - rdPtr;
  assign ocupacao  = 5'(diferenca);
  // Head read is combinational; a same-slot write lands at the edge, after the read.
  assign dadoSaida = mem[rdPtr[AW-1:0]];

  // Pointer update; reset empties the queue.
  always_ff @(posedge clock) begin
    if (reset) begin
      wrPtr <= '0;
      rdPtr <= '0;
    end else begin
      if (doPush) wrPtr <= wrPtr + UM;
      if (doPop)  rdPtr <= rdPtr + UM;
    end
  end

  // Storage write at the tail.
  always_ff @(posedge clock) begin
    if (doPush) mem[wrPtr[AW-1:0]] <= dadoEntrada;
  end

endmodule

// File: rtl/fila_requisicoes.sv
// Request buffer: edge capture, validation, FIFO and paced strobe dispatch to the core.
module fila_requisicoes
  import fila_requisicoes_pkg::*;
#(
  parameter int PROFUNDIDADE  = 4,
  parameter int NUM_ANDARES   = 16,
  parameter int LARGURA_PULSO = 2,
  parameter int INTERVALO     = 4
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       habilitar,
  input  logic [3:0] pedido_origem,
  input  logic [3:0] pedido_destino,
  input  logic       pedido_valido,
  output logic [3:0] origem,
  output logic [3:0] destino,
  output logic       novaEntrada,
  output logic       fila_vazia,
  output logic       fila_cheia,
  output logic       pedido_rejeitado,
  output logic [4:0] db_ocupacao
);

  localparam int CW = maxInt(4, $clog2(maxInt(LARGURA_PULSO, INTERVALO) + 1));
  localparam logic [CW-1:0] CARGA_PULSO     = CW'(LARGURA_PULSO - 1);
  localparam logic [CW-1:0] CARGA_INTERVALO = CW'(INTERVALO - 1);
  localparam logic [CW-1:0] UM              = 1;
  localparam logic [4:0]    LIMITE          = 5'(NUM_ANDARES);

  logic          valido_q;
  logic          captura, invalido, rejeita, push, pop;
  estado_t       estado, estadoProx;
  logic [CW-1:0] contador, contadorProx;
  logic [LARGURA_ENTRADA-1:0] cabeca;

  assign captura  = pedido_valido & ~valido_q;
  assign invalido = (pedido_origem == pedido_destino)
                 || ({1'b0, pedido_origem}  >= LIMITE)
                 || ({1'b0, pedido_destino} >= LIMITE);
  assign rejeita  = invalido || (fila_cheia && !pop);
  assign push     = captura && !rejeita;

  fifo_requisicoes #(.PROFUNDIDADE(PROFUNDIDADE)) uFifo (
    .clock       (clock),
    .reset       (reset),
    .push        (push),
    .pop         (pop),
    .dadoEntrada ({pedido_origem, pedido_destino}),
    .dadoSaida   (cabeca),
    .vazia       (fila_vazia),
    .cheia       (fila_cheia),
    .ocupacao    (db_ocupacao)
  );

  // Dispatch sequencing: one shared down-counter times pulse and gap, loaded on entry.
  always_comb begin
    estadoProx   = estado;
    contadorProx = contador;
    pop          = 1'b0;
    case (estado)
      ST_OCIOSO: begin
        if (habilitar && !fila_vazia) estadoProx = ST_CARREGA;
      end
      ST_CARREGA: begin
        pop          = 1'b1;
        estadoProx   = ST_PULSO;
        contadorProx = CARGA_PULSO;
      end
      ST_PULSO: begin
        if (contador == '0) begin
          estadoProx   = ST_INTERVALO;
          contadorProx = CARGA_INTERVALO;
        end else begin
          contadorProx = contador - UM;
        end
      end
      ST_INTERVALO: begin
        if (contador == '0) estadoProx = ST_OCIOSO;
        else                contadorProx = contador - UM;
      end
      default: estadoProx = ST_OCIOSO;
    endcase
  end

  // State and counter registers.
  always_ff @(posedge clock) begin
    if (reset) begin
      estado   <= ST_OCIOSO;
      contador <= '0;
    end else begin
      estado   <= estadoProx;
      contador <= contadorProx;
    end
  end

  // Registered outputs: strobe follows the next state, pair latched on pop.
  always_ff @(posedge clock) begin
    if (reset) begin
      valido_q         <= 1'b0;
      pedido_rejeitado <= 1'b0;
      novaEntrada      <= 1'b0;
      origem           <= '0;
      destino          <= '0;
    end else begin
      valido_q         <= pedido_valido;
      pedido_rejeitado <= captura && rejeita;
      novaEntrada      <= (estadoProx == ST_PULSO);
      if (pop) begin
        origem  <= cabeca[7:4];
        destino <= cabeca[3:0];
      end
    end
  end

endmodule

// File: tb/tb_fila_requisicoes.sv
// Scoreboard bench: stimulus queues expected pairs, a monitor checks each strobe.
module tb_fila_requisicoes;

  logic       clk;
  logic       rst, hab, pv;
  logic [3:0] po, pd;
  logic [3:0] origem, destino;
  logic       ne, vazia, cheia, rej;
  logic [4:0] occ;

  int compared   = 0;
  int mismatched = 0;
  int cyc        = 0;
  logic [7:0] sb[$];
  int riseCyc[$];

  fila_requisicoes #(
    .PROFUNDIDADE(4), .NUM_ANDARES(12), .LARGURA_PULSO(2), .INTERVALO(4)
  ) dut (
    .clock(clk), .reset(rst), .habilitar(hab),
    .pedido_origem(po), .pedido_destino(pd), .pedido_valido(pv),
    .origem(origem), .destino(destino), .novaEntrada(ne),
    .fila_vazia(vazia), .fila_cheia(cheia), .pedido_rejeitado(rej),
    .db_ocupacao(occ)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  task automatic check(input string nome, input int act, input int exp);
    compared++;
    if (act != exp) begin
      mismatched++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", nome, act, exp, cyc);
    end
  endtask

  // Monitor: pops on each strobe rising edge, checks pair, width and gap.
  initial begin
    logic prevNe;
    int highLen, lowLen;
    logic [7:0] esperado;
    prevNe = 1'b0; highLen = 0; lowLen = 100;
    forever begin
      @(negedge clk);
      if (rst) begin
        prevNe = 1'b0; highLen = 0; lowLen = 100;
      end else begin
        if (ne && !prevNe) begin
          check("gap_ge_4", int'(lowLen >= 4), 1);
          riseCyc.push_back(cyc);
          if (sb.size() == 0) begin
            compared++;
            mismatched++;
            $display("FAIL unexpected_strobe: got %0d,%0d expected none", origem, destino);
          end else begin
            esperado = sb.pop_front();
            check("strobe_pair", int'({origem, destino}), int'(esperado));
          end
          highLen = 1;
        end else if (ne) begin
          highLen++;
        end else begin
          if (prevNe) begin
            check("pulse_width", highLen, 2);
            lowLen = 0;
          end
          lowLen++;
        end
        prevNe = ne;
      end
    end
  end

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic pedido(input logic [3:0] o, input logic [3:0] d, input bit aceita);
    po = o; pd = d; pv = 1'b1;
    tick();
    pv = 1'b0;
    if (aceita) sb.push_back({o, d});
    check("rejeitado_pulse", int'(rej), int'(!aceita));
    tick();
    check("rejeitado_one_cycle", int'(rej), 0);
  endtask

  task automatic checkReset();
    check("rst_novaEntrada", int'(ne), 0);
    check("rst_origem", int'(origem), 0);
    check("rst_destino", int'(destino), 0);
    check("rst_vazia", int'(vazia), 1);
    check("rst_cheia", int'(cheia), 0);
    check("rst_ocupacao", int'(occ), 0);
    check("rst_rejeitado", int'(rej), 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; hab = 1'b0; pv = 1'b0; po = '0; pd = '0;
    repeat (2) tick();
    checkReset();
    rst = 1'b0;
    tick();

    // Single request and 2-cycle latency
    hab = 1'b1;
    pedido(4'd2, 4'd7, 1'b1);
    check("t1_vazia_after_capture", int'(vazia), 0);
    check("t1_no_strobe_yet", int'(ne), 0);
    tick();
    check("t1_strobe_rise", int'(ne), 1);
    check("t1_origem", int'(origem), 2);
    check("t1_destino", int'(destino), 7);
    check("t1_vazia_after_load", int'(vazia), 1);
    repeat (8) tick();
    check("t1_origem_held", int'(origem), 2);

    // Invalid requests: same floor, floor at the limit
    pedido(4'd3, 4'd3, 1'b0);
    check("t2_occ_same", int'(occ), 0);
    pedido(4'd5, 4'd12, 1'b0);
    check("t2_occ_range", int'(occ), 0);
    repeat (4) tick();

    // Overflow with dispatch disabled
    hab = 1'b0;
    pedido(4'd1, 4'd2, 1'b1);
    pedido(4'd3, 4'd4, 1'b1);
    pedido(4'd5, 4'd6, 1'b1);
    pedido(4'd11, 4'd0, 1'b1);
    check("t3_cheia", int'(cheia), 1);
    check("t3_occ4", int'(occ), 4);
    pedido(4'd8, 4'd9, 1'b0);
    check("t3_occ_after_reject", int'(occ), 4);
    riseCyc.delete();
    hab = 1'b1;
    repeat (36) tick();
    check("t3_strobe_count", riseCyc.size(), 4);
    for (int i = 0; i + 1 < riseCyc.size(); i++)
      check("t3_period", riseCyc[i+1] - riseCyc[i], 8);
    check("t3_occ_drained", int'(occ), 0);

    // Full FIFO: push lands on the CARREGA cycle
    hab = 1'b0;
    pedido(4'd1, 4'd9, 1'b1);
    pedido(4'd2, 4'd8, 1'b1);
    pedido(4'd3, 4'd7, 1'b1);
    pedido(4'd4, 4'd6, 1'b1);
    check("t4_cheia", int'(cheia), 1);
    hab = 1'b1;
    tick();
    pedido(4'd5, 4'd10, 1'b1);
    check("t4_occ_unchanged", int'(occ), 4);
    check("t4_cheia_kept", int'(cheia), 1);
    repeat (45) tick();
    check("t4_sb_drained", sb.size(), 0);
    check("t4_occ_drained", int'(occ), 0);

    // Held level yields one capture
    hab = 1'b0;
    po = 4'd4; pd = 4'd9; pv = 1'b1;
    repeat (20) tick();
    pv = 1'b0;
    sb.push_back(8'h49);
    tick();
    check("t5_single_capture", int'(occ), 1);
    pedido(4'd6, 4'd1, 1'b1);
    check("t5_occ2", int'(occ), 2);

    // Reset during the pulse
    hab = 1'b1;
    tick();
    tick();
    check("t5_in_pulse", int'(ne), 1);
    check("t5_occ_in_pulse", int'(occ), 1);
    rst = 1'b1;
    tick();
    sb.delete();
    checkReset();
    po = 4'd7; pd = 4'd8; pv = 1'b1;
    tick();
    rst = 1'b0;
    tick();
    check("t6_capture_after_reset", int'(occ), 1);
    check("t6_vazia", int'(vazia), 0);
    pv = 1'b0;
    sb.push_back(8'h78);
    repeat (14) tick();
    check("t6_sb_drained", sb.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
